led_pattern_gen: RTL
====================

# led_pattern_gen

Parametrised multi-channel LED pattern generator; the next generation of the fixed 1/2/4 Hz and 0.7 s blink counter. One shared prescaler produces a millisecond-class tick. Each of NCH channels runs an independent pattern FSM: off, on, blink with programmable on/off times, or burst (N pulses then a gap). Sits between the board-control logic, which drives the mode and timing buses, and the front-panel LED pins.

## Interface
- CLK_FRQ, 50000000, SYSCLK frequency in Hz
- TICK_HZ, 1000, pattern time base in Hz; DIV = CLK_FRQ/TICK_HZ must be ≥ 2
- NCH, 4, number of LED channels
- TW, 12, width of per-channel ON/OFF time fields, in ticks
- GW, 16, width of per-channel GAP time field, in ticks
- SYSCLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- SYNC  in  1  single-cycle pulse; restarts the prescaler and every channel's pattern
- MODE  in  2*NCH  per channel: 0 off, 1 on, 2 blink, 3 burst (channel i = bits [2i+1:2i])
- ON_T  in  TW*NCH  on-phase length in ticks
- OFF_T  in  TW*NCH  off-phase length in ticks
- BURST_N  in  4*NCH  pulses per burst
- GAP_T  in  GW*NCH  post-burst gap in ticks
- LED_OUT  out  NCH  LED drive; 1 = lit, registered
- TICK  out  1  one-cycle pulse every DIV cycles, registered

## Operation
- Prescaler: counter 0..DIV-1, wraps to 0. TICK = 1 for the cycle after the counter reaches DIV-1. SYNC clears the counter to 0, so the next TICK comes DIV cycles after SYNC.
- Channel FSM states: IDLE, ON_PH, OFF_PH, GAP. Each channel has a phase counter (max of TW, GW bits) and a pulse counter (4 bits).
- Mode 0: state IDLE, LED 0. Mode 1: state IDLE, LED 1.
- Mode 2 (blink):
  - Start: ON_PH, LED 1, counter loaded with ON_T.
  - On each TICK the counter decrements. A TICK with counter == 1 ends the phase.
  - ON_PH end → OFF_PH (load OFF_T, LED 0). OFF_PH end → ON_PH (load ON_T, LED 1).
- Mode 3 (burst):
  - Start: ON_PH, pulse counter = BURST_N.
  - ON_PH end → OFF_PH. OFF_PH end decrements the pulse counter.
  - If the pulse counter is then nonzero → ON_PH. If it is zero → GAP (load GAP_T, LED 0).
  - GAP end → ON_PH with pulse counter reloaded from BURST_N.
- Length fields are sampled only when a phase is loaded. Changes mid-phase take effect at the next load.
- Any length value of 0 is treated as 1.
- BURST_N = 0 in mode 3 behaves as mode 0.
- Mode change: each channel registers its previous MODE. When a change is detected, the channel enters the start state of the new mode on the same edge. No tick wait, no completion of the old phase.
- SYNC: every channel re-enters its current mode's start state on the same edge as the prescaler clear. Used to phase-align channels.
- Channels are fully independent apart from the shared TICK.

## Timing
- Reset (async assert, sync release): LED_OUT = 0, TICK = 0, prescaler = 0, all FSMs IDLE, all counters 0, previous-mode registers 0.
  - After release, a channel whose MODE ≠ 0 sees a mode change on the first edge and starts its pattern.
- LED_OUT changes one SYSCLK edge after the event that causes it: a TICK cycle, a mode change or SYNC.
- Steady-state phase of length L lasts exactly L*DIV cycles.
- First phase after a mode change lasts (L-1)*DIV + d cycles, where d (1..DIV) is the distance to the next TICK. After SYNC, d = DIV exactly.
- Blink period = (ON_T + OFF_T)*DIV cycles. Burst period = (BURST_N*(ON_T + OFF_T) + GAP_T)*DIV cycles.
- Mode change and SYNC in the same cycle: the result is identical, start state of the new mode.
- Mode change in the same cycle as TICK: the mode change wins and the tick is ignored for that channel.
- Counter underflow is impossible: a phase always ends at count 1.

## Test plan
Bench settings: CLK_FRQ=1000, TICK_HZ=100 (DIV=10), NCH=4.
1. Reset, then hold. Required: LED_OUT=0 and TICK=0 during reset; TICK is high 1 cycle in every 10; prescaler wraps cleanly.
2. Ch0 mode 2, ON_T=3, OFF_T=2, SYNC pulse. Required: LED0 high for 30 cycles, low for 20, period 50 over ≥4 periods.
3. Ch1 mode 3, ON_T=1, OFF_T=1, BURST_N=3, GAP_T=5, SYNC. Required: three 10-cycle pulses spaced 10 cycles apart, then 50 low plus the preceding 10 low, repeating every 110 cycles.
4. Zero and degenerate fields: ON_T=0, OFF_T=0 in mode 2 → toggle every 10 cycles. BURST_N=0 in mode 3 → LED stays 0. Modes 0 and 1 → constant 0 and 1.
5. Switch ch2 from mode 2 to mode 1 mid-ON_PH, in the same cycle as TICK. Required: LED2=1 on the next edge and held. Switch back to mode 2: a fresh ON_PH starts, with first-phase length per the (L-1)*DIV + d rule.
6. Two channels in identical blink mode, started 7 cycles apart, then SYNC. Required: both LED_OUT bits identical from the SYNC edge onward. Also assert RESET_N mid-phase → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick, per-channel off/on/blink/burst FSM.
// Latency: LED_OUT and TICK are registered and change one SYSCLK edge after the tick, mode change or SYNC that causes them.
// Backpressure: none; the control buses are sampled every cycle and the outputs are free-running.
//
// Ports:
//   SYSCLK, RESET_N          system clock, asynchronous active-low reset
//   SYNC                     one-cycle pulse; clears the prescaler and restarts every channel
//   MODE[2*NCH]              per channel: 0 off, 1 on, 2 blink, 3 burst
//   ON_T/OFF_T[TW*NCH]       on/off phase lengths in ticks (0 behaves as 1)
//   BURST_N[4*NCH]           pulses per burst (0 in burst mode behaves as off)
//   GAP_T[GW*NCH]            post-burst gap in ticks (0 behaves as 1)
//   LED_OUT[NCH]             LED drive, 1 = lit
//   TICK                     one-cycle pulse every DIV = CLK_FRQ/TICK_HZ cycles
module led_pattern_gen #(
  parameter int CLK_FRQ = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int TW      = 12,
  parameter int GW      = 16
) (
  input  logic              SYSCLK,
  input  logic              RESET_N,
  input  logic              SYNC,
  input  logic [2*NCH-1:0]  MODE,
  input  logic [TW*NCH-1:0] ON_T,
  input  logic [TW*NCH-1:0] OFF_T,
  input  logic [4*NCH-1:0]  BURST_N,
  input  logic [GW*NCH-1:0] GAP_T,
  output logic [NCH-1:0]    LED_OUT,
  output logic              TICK
);

  localparam int DIV = CLK_FRQ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  // One phase counter serves ON/OFF and GAP lengths, so it spans the wider field.
  localparam int PW  = (TW > GW) ? TW : GW;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  // Channel FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ON_PH  = 2'd1;
  localparam logic [1:0] ST_OFF_PH = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  // Mode encodings on the MODE bus.
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  // A zero length would never reach the count-of-1 end condition, so it is
  // promoted to one tick at load time.
  function automatic logic [PW-1:0] len_tw(input logic [TW-1:0] v);
    return (v == '0) ? PW'(1) : PW'(v);
  endfunction

  function automatic logic [PW-1:0] len_gw(input logic [GW-1:0] v);
    return (v == '0) ? PW'(1) : PW'(v);
  endfunction

  // --------------------------------------------------------------------------
  // Shared prescaler
  // --------------------------------------------------------------------------
  logic [CW-1:0] pre_cnt_d, pre_cnt_q;
  logic          tick_d, tick_q;

  // tick_d marks the wrap cycle. Channels act on it directly so their phase
  // boundaries land on the same edge that raises TICK; SYNC suppresses it so
  // the first tick after SYNC is a full DIV cycles away.
  always_comb begin
    tick_d    = 1'b0;
    pre_cnt_d = pre_cnt_q + CW'(1);
    if (SYNC) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == DIV_LAST) begin
      pre_cnt_d = '0;
      tick_d    = 1'b1;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign TICK = tick_q;

  // --------------------------------------------------------------------------
  // Per-channel pattern FSMs
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [1:0]    mode_i;
    logic [TW-1:0] on_t_i;
    logic [TW-1:0] off_t_i;
    logic [3:0]    burst_n_i;
    logic [GW-1:0] gap_t_i;
    logic          restart;

    logic [1:0]    state_d, state_q;
    logic [PW-1:0] phase_d, phase_q;
    logic [3:0]    pulse_d, pulse_q;
    logic [1:0]    mode_prev_d, mode_prev_q;
    logic          led_d, led_q;

    assign mode_i    = MODE[2*gi +: 2];
    assign on_t_i    = ON_T[TW*gi +: TW];
    assign off_t_i   = OFF_T[TW*gi +: TW];
    assign burst_n_i = BURST_N[4*gi +: 4];
    assign gap_t_i   = GAP_T[GW*gi +: GW];

    // A mode change (including the first edge after reset, since the
    // previous-mode register resets to off) or SYNC puts the channel in the
    // start state of its current mode, overriding any tick in the same cycle.
    assign restart = SYNC | (mode_i != mode_prev_q);

    always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      pulse_d     = pulse_q;
      led_d       = led_q;
      mode_prev_d = mode_i;

      if (restart) begin
        case (mode_i)
          MODE_OFF: begin
            state_d = ST_IDLE;
            phase_d = '0;
            pulse_d = '0;
            led_d   = 1'b0;
          end
          MODE_ON: begin
            state_d = ST_IDLE;
            phase_d = '0;
            pulse_d = '0;
            led_d   = 1'b1;
          end
          MODE_BLINK: begin
            state_d = ST_ON_PH;
            phase_d = len_tw(on_t_i);
            pulse_d = '0;
            led_d   = 1'b1;
          end
          default: begin
            // Burst with zero pulses parks dark, exactly like mode 0.
            if (burst_n_i == '0) begin
              state_d = ST_IDLE;
              phase_d = '0;
              pulse_d = '0;
              led_d   = 1'b0;
            end else begin
              state_d = ST_ON_PH;
              phase_d = len_tw(on_t_i);
              pulse_d = burst_n_i;
              led_d   = 1'b1;
            end
          end
        endcase
      end else if (tick_d && (state_q != ST_IDLE)) begin
        if (phase_q != PW'(1)) begin
          phase_d = phase_q - PW'(1);
        end else begin
          // Phase ends on the tick that sees a count of 1.
          case (state_q)
            ST_ON_PH: begin
              state_d = ST_OFF_PH;
              phase_d = len_tw(off_t_i);
              led_d   = 1'b0;
            end
            ST_OFF_PH: begin
              if (mode_i == MODE_BURST) begin
                pulse_d = pulse_q - 4'd1;
                if (pulse_q == 4'd1) begin
                  // Last pulse of the burst done: go dark for the gap.
                  state_d = ST_GAP;
                  phase_d = len_gw(gap_t_i);
                  led_d   = 1'b0;
                end else begin
                  state_d = ST_ON_PH;
                  phase_d = len_tw(on_t_i);
                  led_d   = 1'b1;
                end
              end else begin
                state_d = ST_ON_PH;
                phase_d = len_tw(on_t_i);
                led_d   = 1'b1;
              end
            end
            ST_GAP: begin
              // BURST_N is re-read here, so a burst count cleared while in
              // the gap drops the channel to dark idle.
              if (burst_n_i == '0) begin
                state_d = ST_IDLE;
                phase_d = '0;
                pulse_d = '0;
                led_d   = 1'b0;
              end else begin
                state_d = ST_ON_PH;
                phase_d = len_tw(on_t_i);
                pulse_d = burst_n_i;
                led_d   = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q     <= ST_IDLE;
        phase_q     <= '0;
        pulse_q     <= '0;
        mode_prev_q <= MODE_OFF;
        led_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        phase_q     <= phase_d;
        pulse_q     <= pulse_d;
        mode_prev_q <= mode_prev_d;
        led_q       <= led_d;
      end
    end

    assign LED_OUT[gi] = led_q;
  end

endmodule
